// File: rtl/gate_sensor_decoder_if.sv
// -----------------------------------------------------------------------------
// gate_sensor_decoder_if
// Groups the parking-gate sensor inputs, the occupancy count fed back from the
// counter, and the decoder's strobe/status outputs into one bundle.
//
// Signals:
//   sens_a     street-side beam, 1 = blocked (asynchronous to clk)
//   sens_b     lot-side beam, 1 = blocked (asynchronous to clk)
//   count      current occupancy from the counter
//   count_up   one-cycle strobe, vehicle entered
//   count_down one-cycle strobe, vehicle exited
//   gate_open  entry barrier raise request
//   lot_full   registered, count >= CAPACITY
//   seq_error  one-cycle strobe, refused/illegal/aborted sequence
//
// Modports:
//   master  drives the sensors and count, observes the decoder outputs
//   slave   the decoder itself
// -----------------------------------------------------------------------------
interface gate_sensor_decoder_if;
    logic       sens_a;
    logic       sens_b;
    logic [3:0] count;
    logic       count_up;
    logic       count_down;
    logic       gate_open;
    logic       lot_full;
    logic       seq_error;

    modport master (
        output sens_a, sens_b, count,
        input  count_up, count_down, gate_open, lot_full, seq_error
    );

    modport slave (
        input  sens_a, sens_b, count,
        output count_up, count_down, gate_open, lot_full, seq_error
    );
endinterface

// File: rtl/gate_sensor_decoder.sv
// -----------------------------------------------------------------------------
// gate_sensor_decoder
// Decodes the two beam sensors of a parking gate into count_up / count_down
// strobes for the occupancy counter. Sensor A is street side, B is lot side:
// entry is A, AB, B, clear; exit is B, BA, A, clear.
//
// Each sensor goes through a 2-flop synchronizer and a debounce counter. The
// sequence FSM runs on the debounced pair {a_d, b_d}; all outputs are
// registered.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    gate_sensor_decoder_if.slave (sensors, count in; strobes out)
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive equal samples needed to accept a level (>= 1)
//   CAPACITY         lot capacity, entry refused when count >= CAPACITY (1..15)
//   TIMEOUT_CYCLES   cycles a non-idle state may persist (timeout build only)
//
// Build option:
//   GATE_SENSOR_TIMEOUT_EN  when defined, a state that persists for
//                           TIMEOUT_CYCLES aborts to WAIT_CLR with seq_error.
//                           When undefined the FSM waits indefinitely.
// -----------------------------------------------------------------------------
module gate_sensor_decoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CAPACITY        = 9,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gate_sensor_decoder_if.slave   bus
);

    localparam int         DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [3:0] CAP  = 4'(CAPACITY);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EN_A,
        ST_EN_AB,
        ST_EN_B,
        ST_EX_B,
        ST_EX_BA,
        ST_EX_A,
        ST_WAIT_CLR
    } state_t;

    // Bit 1 = sensor A, bit 0 = sensor B.
    logic [1:0] w_raw;
    logic [1:0] w_ab;

    assign w_raw = {bus.sens_a, bus.sens_b};

    // -------------------------------------------------------------------------
    // Input conditioning: synchronizer + debounce, one copy per sensor.
    // The debounced level moves only after DEBOUNCE_CYCLES consecutive
    // synchronized samples that all differ from it; any sample matching the
    // current level restarts the count.
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < 2; g++) begin : g_cond
        logic            r_meta;
        logic            r_sync;
        logic            r_lvl;
        logic [DB_W-1:0] r_cnt;

        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // the pre-edge value of its neighbours, as real flops do.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_meta <= 1'b0;
                r_sync <= 1'b0;
                r_lvl  <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_meta <= w_raw[g];
                r_sync <= r_meta;
                if (r_sync == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_lvl <= r_sync;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_ab[g] = r_lvl;
    end

    // -------------------------------------------------------------------------
    // Sequence FSM and registered outputs
    // -------------------------------------------------------------------------
    state_t r_state;
    logic   r_count_up;
    logic   r_count_down;
    logic   r_gate_open;
    logic   r_lot_full;
    logic   r_seq_error;

`ifdef GATE_SENSOR_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic            w_hold;
    logic            w_timeout;
    logic [TO_W-1:0] r_timer;

    // w_hold: the current debounced input keeps the FSM in its present state.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_hold = 1'b0;
        case (r_state)
            ST_IDLE:     w_hold = (w_ab == 2'b00);
            ST_EN_A:     w_hold = (w_ab == 2'b10);
            ST_EN_AB:    w_hold = (w_ab == 2'b11);
            ST_EN_B:     w_hold = (w_ab == 2'b01);
            ST_EX_B:     w_hold = (w_ab == 2'b01);
            ST_EX_BA:    w_hold = (w_ab == 2'b11);
            ST_EX_A:     w_hold = (w_ab == 2'b10);
            ST_WAIT_CLR: w_hold = (w_ab != 2'b00);
            default:     w_hold = 1'b0;
        endcase
    end

    assign w_timeout = (r_state != ST_IDLE) && w_hold &&
                       (r_timer == TO_W'(TIMEOUT_CYCLES - 1));

    // Counts cycles spent in the present non-idle state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (r_state == ST_IDLE || !w_hold || w_timeout) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_count_up   <= 1'b0;
            r_count_down <= 1'b0;
            r_gate_open  <= 1'b0;
            r_lot_full   <= 1'b0;
            r_seq_error  <= 1'b0;
        end else begin
            r_count_up   <= 1'b0;
            r_count_down <= 1'b0;
            r_seq_error  <= 1'b0;
            r_lot_full   <= (bus.count >= CAP);

            // r_gate_open holds the decision latched at IDLE->EN_A while the
            // FSM stays within the entry states, and drops on any other exit.
            case (r_state)
                ST_IDLE: begin
                    case (w_ab)
                        2'b10: begin
                            r_state     <= ST_EN_A;
                            r_gate_open <= ~r_lot_full;
                        end
                        2'b01: r_state <= ST_EX_B;
                        2'b11: begin
                            r_state     <= ST_WAIT_CLR;
                            r_seq_error <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_EN_A: begin
                    case (w_ab)
                        2'b11: r_state <= ST_EN_AB;
                        2'b00: begin
                            r_state     <= ST_IDLE;
                            r_gate_open <= 1'b0;
                        end
                        2'b01: begin
                            r_state     <= ST_WAIT_CLR;
                            r_gate_open <= 1'b0;
                            r_seq_error <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_EN_AB: begin
                    case (w_ab)
                        2'b01: r_state <= ST_EN_B;
                        2'b10: r_state <= ST_EN_A;
                        2'b00: begin
                            r_state     <= ST_IDLE;
                            r_gate_open <= 1'b0;
                            r_seq_error <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_EN_B: begin
                    case (w_ab)
                        2'b00: begin
                            r_state     <= ST_IDLE;
                            r_gate_open <= 1'b0;
                            if (bus.count < CAP) r_count_up  <= 1'b1;
                            else                 r_seq_error <= 1'b1;
                        end
                        2'b11: r_state <= ST_EN_AB;
                        2'b10: begin
                            r_state     <= ST_WAIT_CLR;
                            r_gate_open <= 1'b0;
                            r_seq_error <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_EX_B: begin
                    case (w_ab)
                        2'b11: r_state <= ST_EX_BA;
                        2'b00: r_state <= ST_IDLE;
                        2'b10: begin
                            r_state     <= ST_WAIT_CLR;
                            r_seq_error <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_EX_BA: begin
                    case (w_ab)
                        2'b10: r_state <= ST_EX_A;
                        2'b01: r_state <= ST_EX_B;
                        2'b00: begin
                            r_state     <= ST_IDLE;
                            r_seq_error <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_EX_A: begin
                    case (w_ab)
                        2'b00: begin
                            r_state <= ST_IDLE;
                            if (bus.count != 4'd0) r_count_down <= 1'b1;
                            else                   r_seq_error  <= 1'b1;
                        end
                        2'b11: r_state <= ST_EX_BA;
                        2'b01: begin
                            r_state     <= ST_WAIT_CLR;
                            r_seq_error <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_WAIT_CLR: begin
                    if (w_ab == 2'b00) r_state <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_gate_open <= 1'b0;
                end
            endcase

`ifdef GATE_SENSOR_TIMEOUT_EN
            // Abort overrides the case above; it only fires when the inputs
            // would otherwise hold the state, so no completion is lost.
            if (w_timeout) begin
                r_state      <= (w_ab == 2'b00) ? ST_IDLE : ST_WAIT_CLR;
                r_gate_open  <= 1'b0;
                r_count_up   <= 1'b0;
                r_count_down <= 1'b0;
                r_seq_error  <= 1'b1;
            end
`endif
        end
    end

    assign bus.count_up   = r_count_up;
    assign bus.count_down = r_count_down;
    assign bus.gate_open  = r_gate_open;
    assign bus.lot_full   = r_lot_full;
    assign bus.seq_error  = r_seq_error;

endmodule

// File: tb/tb_gate_sensor_decoder.sv
// -----------------------------------------------------------------------------
// tb_gate_sensor_decoder
// Drives gate_sensor_decoder through directed gate scenarios and randomized
// sensor sequences. A behavioural model (sample-window debounce plus a
// declarative transition table) predicts every output every cycle.
// -----------------------------------------------------------------------------
module tb_gate_sensor_decoder;

    localparam int DEB = 4;
    localparam int CAP = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    gate_sensor_decoder_if bus ();

    gate_sensor_decoder #(
        .DEBOUNCE_CYCLES(DEB),
        .CAPACITY       (CAP),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    typedef struct {
        string      from;
        logic [1:0] ab;
        string      to;
        string      ev;
    } rule_t;

    rule_t rules[$];

    function automatic void add_rule(string f, logic [1:0] ab, string t, string ev);
        rule_t r;
        r.from = f; r.ab = ab; r.to = t; r.ev = ev;
        rules.push_back(r);
    endfunction

    function automatic void build_rules();
        add_rule("IDLE",  2'b10, "EN_A",     "");
        add_rule("IDLE",  2'b01, "EX_B",     "");
        add_rule("IDLE",  2'b11, "WAIT_CLR", "err");
        add_rule("EN_A",  2'b11, "EN_AB",    "");
        add_rule("EN_A",  2'b00, "IDLE",     "");
        add_rule("EN_A",  2'b01, "WAIT_CLR", "err");
        add_rule("EN_AB", 2'b01, "EN_B",     "");
        add_rule("EN_AB", 2'b10, "EN_A",     "");
        add_rule("EN_AB", 2'b00, "IDLE",     "err");
        add_rule("EN_B",  2'b00, "IDLE",     "enter");
        add_rule("EN_B",  2'b11, "EN_AB",    "");
        add_rule("EN_B",  2'b10, "WAIT_CLR", "err");
        add_rule("EX_B",  2'b11, "EX_BA",    "");
        add_rule("EX_B",  2'b00, "IDLE",     "");
        add_rule("EX_B",  2'b10, "WAIT_CLR", "err");
        add_rule("EX_BA", 2'b10, "EX_A",     "");
        add_rule("EX_BA", 2'b01, "EX_B",     "");
        add_rule("EX_BA", 2'b00, "IDLE",     "err");
        add_rule("EX_A",  2'b00, "IDLE",     "leave");
        add_rule("EX_A",  2'b11, "EX_BA",    "");
        add_rule("EX_A",  2'b01, "WAIT_CLR", "err");
        add_rule("WAIT_CLR", 2'b00, "IDLE",  "");
    endfunction

    string    m_state;
    bit [1:0] m_lvl;
    bit       m_up, m_down, m_err, m_gate, m_full;
    bit [1:0] m_hist[$];   // raw {a,b} seen at the last DEB+2 edges, oldest first

    function automatic void model_reset();
        m_state = "IDLE";
        m_lvl = 2'b00;
        m_up = 0; m_down = 0; m_err = 0; m_gate = 0; m_full = 0;
        m_hist.delete();
        for (int i = 0; i < DEB + 2; i++) m_hist.push_back(2'b00);
    endfunction

    function automatic void model_step(bit [1:0] raw, int cnt);
        string nxt = m_state;
        string ev  = "";
        bit    flip;
        foreach (rules[i])
            if (rules[i].from == m_state && rules[i].ab == m_lvl) begin
                nxt = rules[i].to;
                ev  = rules[i].ev;
            end
        m_up   = (ev == "enter") && (cnt < CAP);
        m_down = (ev == "leave") && (cnt != 0);
        m_err  = (ev == "err") || (ev == "enter" && cnt >= CAP) ||
                 (ev == "leave" && cnt == 0);
        if (m_state == "IDLE" && nxt == "EN_A") m_gate = !m_full;
        else if (nxt.substr(0, 1) != "EN")      m_gate = 0;
        m_state = nxt;
        // The level accepted at this edge reflects the synchronized samples of
        // raw inputs from 2..DEB+1 edges ago: all must disagree with it.
        m_hist.push_back(raw);
        void'(m_hist.pop_front());
        for (int k = 0; k < 2; k++) begin
            flip = 1;
            for (int j = 0; j < DEB; j++)
                if (m_hist[j][k] == m_lvl[k]) flip = 0;
            if (flip) m_lvl[k] = ~m_lvl[k];
        end
        m_full = (cnt >= CAP);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step({bus.sens_a, bus.sens_b}, int'(bus.count));
    end

    // --------------------------------------------------------------- monitor
    int cyc = 0;
    int n_up = 0, n_down = 0, n_err = 0;
    int up_cyc = -1;
    bit gate_seen = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        check("outputs{up,down,gate,full,err}",
              {27'd0, bus.count_up, bus.count_down, bus.gate_open, bus.lot_full, bus.seq_error},
              {27'd0, m_up, m_down, m_gate, m_full, m_err});
        if (bus.count_up)   begin n_up++; up_cyc = cyc; end
        if (bus.count_down) n_down++;
        if (bus.seq_error)  n_err++;
        if (bus.gate_open)  gate_seen = 1;
    end

    // ------------------------------------------------------------- stimulus
    task automatic hold(input logic [1:0] ab, input int n);
        @(negedge clk);
        bus.sens_a = ab[1];
        bus.sens_b = ab[0];
        repeat (n - 1) @(negedge clk);
    endtask

    int s_up, s_down, s_err;

    task automatic snap();
        s_up = n_up; s_down = n_down; s_err = n_err; gate_seen = 0;
    endtask

    function automatic logic [3:0] pick_count();
        case ($urandom_range(0, 5))
            0: return 4'd0;
            1: return 4'd3;
            2: return 4'(CAP - 1);
            3: return 4'(CAP);
            4: return 4'd15;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    int t0;

    initial begin
        build_rules();
        model_reset();
        bus.sens_a = 0;
        bus.sens_b = 0;
        bus.count  = 4'd3;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {27'd0, bus.count_up, bus.count_down, bus.gate_open, bus.lot_full, bus.seq_error}, 32'd0);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Entry at count=3: one count_up, 7 cycles after clear.
        snap();
        hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10);
        @(negedge clk); bus.sens_a = 0; bus.sens_b = 0; t0 = cyc;
        repeat (12) @(negedge clk);
        check("entry_up_count", n_up - s_up, 1);
        check("entry_up_latency", up_cyc - t0, 7);
        check("entry_gate_seen", gate_seen, 1);
        check("entry_no_err", n_err - s_err, 0);

        // Exit at count=3.
        snap();
        hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 12);
        check("exit_down_count", n_down - s_down, 1);
        check("exit_gate_closed", gate_seen, 0);
        check("exit_no_err", n_err - s_err, 0);

        // Full lot.
        bus.count = 4'(CAP);
        repeat (2) @(negedge clk);
        check("full_flag", bus.lot_full, 1);
        snap();
        hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 12);
        check("full_gate_closed", gate_seen, 0);
        check("full_no_up", n_up - s_up, 0);
        check("full_one_err", n_err - s_err, 1);

        // Exit at empty lot.
        bus.count = 4'd0;
        snap();
        hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 12);
        check("empty_no_down", n_down - s_down, 0);
        check("empty_one_err", n_err - s_err, 1);

        // Backout: A then clear.
        bus.count = 4'd3;
        snap();
        hold(2'b10, 10); hold(2'b00, 12);
        check("backout_strobes", (n_up - s_up) + (n_down - s_down) + (n_err - s_err), 0);

        // Short glitches on A.
        snap();
        repeat (3) begin hold(2'b10, 2); hold(2'b00, 6); end
        hold(2'b00, 8);
        check("glitch_gate", gate_seen, 0);
        check("glitch_strobes", (n_up - s_up) + (n_err - s_err), 0);

        // Both sensors at once, then B, then clear.
        snap();
        hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 12);
        check("illegal_one_err", n_err - s_err, 1);
        check("illegal_no_count", (n_up - s_up) + (n_down - s_down), 0);

        // Reset while in EN_AB.
        hold(2'b10, 10); hold(2'b11, 10);
        check("pre_reset_gate", bus.gate_open, 1);
        snap();
        #2 rst_n = 1'b0;
        #1 check("reset_mid_outputs",
                 {27'd0, bus.count_up, bus.count_down, bus.gate_open, bus.lot_full, bus.seq_error}, 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        hold(2'b01, 10); hold(2'b00, 12);
        check("reset_no_up", n_up - s_up, 0);

        // Randomized sequences, all checked against the model each cycle.
        repeat (80) begin
            bus.count = pick_count();
            case ($urandom_range(0, 5))
                0, 5: begin
                    hold(2'b10, $urandom_range(5, 12));
                    hold(2'b11, $urandom_range(5, 12));
                    if ($urandom_range(0, 1) != 0) bus.count = pick_count();
                    hold(2'b01, $urandom_range(5, 12));
                end
                1: begin
                    hold(2'b01, $urandom_range(5, 12));
                    hold(2'b11, $urandom_range(5, 12));
                    hold(2'b10, $urandom_range(5, 12));
                end
                2: repeat (6) hold(2'($urandom_range(0, 3)), $urandom_range(1, 10));
                3: repeat (4) begin
                    hold(2'($urandom_range(1, 3)), $urandom_range(1, 3));
                    hold(2'b00, $urandom_range(1, 4));
                end
                default: begin
                    hold(2'b11, $urandom_range(5, 12));
                    hold(2'($urandom_range(0, 3)), $urandom_range(5, 12));
                end
            endcase
            hold(2'b00, 14);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_sensor_decoder.md
Name: gate_sensor_decoder

Overview:
- Decodes two vehicle beam sensors at the parking gate into single-cycle count_up / count_down strobes for the occupancy counter.
- Sensor A sits on the street side and sensor B on the lot side. Entry is the ordered sequence A, AB, B, clear. Exit is B, BA, A, clear.
- Takes the occupancy count back from the counter. Uses it to drive the gate/full indications and to suppress strobes that would push the count out of range.

Parameters:
- DEBOUNCE_CYCLES, 4, number of consecutive identical synchronized samples required before a sensor level is accepted (min 1).
- CAPACITY, 9, lot capacity. Entry is refused when count >= CAPACITY (1..15).
- TIMEOUT_CYCLES, 1000, cycles a non-idle state may persist before abort (used only with TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sens_a  in  1  street-side beam, 1 = blocked, asynchronous to clk.
- sens_b  in  1  lot-side beam, 1 = blocked, asynchronous to clk.
- count  in  4  current occupancy from counter.
- count_up  out  1  one-cycle strobe, vehicle entered.
- count_down  out  1  one-cycle strobe, vehicle exited.
- gate_open  out  1  entry barrier raise request.
- lot_full  out  1  registered, count >= CAPACITY.
- seq_error  out  1  one-cycle strobe, refused entry / exit at zero / illegal sequence / timeout.

Behaviour:
- Reset (rst_n low, async): all outputs 0, FSM = IDLE, synchronizers and debounce state 0 (both sensors considered clear). Release is synchronous to clk.
- Input conditioning: each sensor passes a 2-flop synchronizer, then a per-sensor debounce counter.
  - Debounced level a_d / b_d changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples differing from the current level.
  - A raw edge reaches a_d / b_d after 2 + DEBOUNCE_CYCLES cycles.
- FSM runs on {a_d, b_d}. States: IDLE, EN_A, EN_AB, EN_B, EX_B, EX_BA, EX_A, WAIT_CLR.
- IDLE transitions:
  - 10 -> EN_A.
  - 01 -> EX_B.
  - 11 -> WAIT_CLR, with a seq_error pulse.
  - 00 -> stay.
- EN_A transitions: 11 -> EN_AB; 00 -> IDLE (backed out, no strobe); 01 -> WAIT_CLR + seq_error.
- EN_AB transitions: 01 -> EN_B; 10 -> EN_A; 00 -> IDLE + seq_error.
- EN_B transitions:
  - 00 -> IDLE, completing the entry: count_up pulse if count < CAPACITY, else seq_error pulse and no count_up.
  - 11 -> EN_AB.
  - 10 -> WAIT_CLR + seq_error.
- Exit states mirror the entry states with A and B swapped. Completion in EX_A on 00: count_down pulse if count != 0, else seq_error pulse and no count_down.
- WAIT_CLR: stay until 00, then -> IDLE.
- Strobe timing:
  - count_up, count_down and seq_error are registered and assert in the cycle after the completing debounced transition.
  - Each strobe is exactly 1 cycle wide.
  - count_up and count_down are never asserted together.
- lot_full: registered compare, 1-cycle latency from count.
- gate_open: registered. Equals 1 while the FSM is in EN_A, EN_AB or EN_B and lot_full = 0 at EN_A entry (value latched on IDLE->EN_A). Otherwise 0.
- count is sampled at the completion cycle. Changes of count mid-sequence affect only lot_full, not the latched gate decision.
- Sensor glitches shorter than DEBOUNCE_CYCLES: no FSM effect.
- Reset mid-sequence: FSM returns to IDLE, no strobe emitted. If a sensor is still blocked after release, normal decoding resumes from IDLE.

Optional Feature:
- Macro: GATE_SENSOR_TIMEOUT_EN.
- Defined:
  - A timeout counter clears on every state change and increments while the FSM is in any state other than IDLE.
  - On reaching TIMEOUT_CYCLES the FSM goes to WAIT_CLR with a seq_error pulse and no count strobe. If the sensors are already 00, it goes to IDLE.
- Undefined: no timeout counter is present, and the FSM waits indefinitely in any state.

Test Plan:
- Entry: count=3, drive A, AB, B, clear, each held 10 cycles -> exactly one count_up pulse, 2+4+1 cycles after the final clear. gate_open=1 from the A phase to the end of the sequence. No seq_error.
- Exit: count=3, drive B, BA, A, clear -> one count_down pulse. gate_open stays 0.
- Full lot: count=9 with CAPACITY=9 -> lot_full=1. A full entry sequence gives gate_open=0, no count_up, and one seq_error at completion.
- Exit at empty and backout:
  - count=0, full exit sequence -> seq_error only, no count_down.
  - A, then clear (backout) -> no strobes.
- Glitches and illegal start: 2-cycle pulses on sens_a -> FSM stays IDLE. Both sensors rising on the same cycle -> seq_error, then no strobe until both clear.
- Reset mid-entry, plus timeout:
  - Assert rst_n=0 while in EN_AB -> all outputs 0 immediately. The FSM returns to IDLE and no count_up is emitted after release.
  - With GATE_SENSOR_TIMEOUT_EN and TIMEOUT_CYCLES=50, hold A for 60 cycles -> seq_error about 50 cycles after EN_A entry.
